edge_det_multi: RTL and testbench

EDGE_DET_MULTI -- requirements
Module: edge_det_multi

---
 rtl/edge_det_pkg.sv | 21 ++
 rtl/edge_det_chan.sv | 134 +++++++++++++
 rtl/edge_det_multi.sv | 39 +++
 tb/tb_edge_det_multi.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared types for the multi-channel edge detector: the per-channel
// filter FSM state and the per-channel edge-reporting mode.
package edge_det_pkg;

   // S_* = level accepted and stable, P_* = candidate new level being filtered
   typedef enum logic [1:0] {
      S_LOW  = 2'b00,
      P_HIGH = 2'b01,
      S_HIGH = 2'b10,
      P_LOW  = 2'b11
   } state_e;

   // Which accepted edges raise a tick; the FSM itself ignores mode
   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: glitch-filter FSM, mode-gated Mealy tick,
// sticky event flag and saturating event counter.
module edge_det_chan
   import edge_det_pkg::*;
#(
   parameter int FILT_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              level,
   input  logic [1:0]        mode,
   input  logic [FILT_W-1:0] filt_len,
   input  logic              clr,
   input  logic              cnt_clr,
   output logic              tick,
   output logic              sticky,
   output logic [CNT_W-1:0]  evt_cnt
);

   localparam logic [FILT_W-1:0] FCNT_ONE = FILT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   state_e            state, state_nxt;
   logic [FILT_W-1:0] fcnt, fcnt_nxt;
   logic              rise, fall;
   mode_e             mode_sel;
   logic              want_rise, want_fall;

   assign mode_sel  = mode_e'(mode);
   assign want_rise = (mode_sel == MODE_RISE) || (mode_sel == MODE_BOTH);
   assign want_fall = (mode_sel == MODE_FALL) || (mode_sel == MODE_BOTH);

   // Next-state and edge-acceptance logic; an edge is accepted once the new
   // level has been seen for filt_len+1 consecutive cycles.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // can leave one unassigned and infer a latch.
      state_nxt = state;
      fcnt_nxt  = fcnt;
      rise      = 1'b0;
      fall      = 1'b0;
      case (state)
         S_LOW: begin
            if (level) begin
               if (filt_len == '0) begin
                  rise      = 1'b1;
                  state_nxt = S_HIGH;
               end else begin
                  state_nxt = P_HIGH;
                  fcnt_nxt  = FCNT_ONE;
               end
            end
         end
         P_HIGH: begin
            if (!level) begin
               state_nxt = S_LOW;
               fcnt_nxt  = '0;
            end else if (fcnt >= filt_len) begin
               // >= so a shortened filt_len releases an already-long pending run
               rise      = 1'b1;
               state_nxt = S_HIGH;
               fcnt_nxt  = '0;
            end else begin
               fcnt_nxt  = fcnt + FCNT_ONE;
            end
         end
         S_HIGH: begin
            if (!level) begin
               if (filt_len == '0) begin
                  fall      = 1'b1;
                  state_nxt = S_LOW;
               end else begin
                  state_nxt = P_LOW;
                  fcnt_nxt  = FCNT_ONE;
               end
            end
         end
         P_LOW: begin
            if (level) begin
               state_nxt = S_HIGH;
               fcnt_nxt  = '0;
            end else if (fcnt >= filt_len) begin
               fall      = 1'b1;
               state_nxt = S_LOW;
               fcnt_nxt  = '0;
            end else begin
               fcnt_nxt  = fcnt + FCNT_ONE;
            end
         end
         default: begin
            state_nxt = S_LOW;
            fcnt_nxt  = '0;
         end
      endcase
   end

   // Mode only gates the pulse, so mode changes never create a tick
   assign tick = !rst && ((rise && want_rise) || (fall && want_fall));

   // FSM state and filter counter register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state <= S_LOW;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   // Sticky flag and saturating event counter; a tick wins over a clear
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky  <= 1'b0;
         evt_cnt <= '0;
      end else begin
         if (tick) begin
            sticky <= 1'b1;
         end else if (clr) begin
            sticky <= 1'b0;
         end
         if (cnt_clr) begin
            evt_cnt <= tick ? CNT_ONE : '0;
         end else if (tick && (evt_cnt != CNT_MAX)) begin
            evt_cnt <= evt_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/edge_det_multi.sv
// NCH independent filtered edge detectors sharing one filter length.
module edge_det_multi
   import edge_det_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int FILT_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       level,
   input  logic [2*NCH-1:0]     mode,
   input  logic [FILT_W-1:0]    filt_len,
   input  logic [NCH-1:0]       clr,
   input  logic [NCH-1:0]       cnt_clr,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       sticky,
   output logic [NCH*CNT_W-1:0] evt_cnt
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      edge_det_chan #(
         .FILT_W (FILT_W),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .level    (level[i]),
         .mode     (mode[2*i +: 2]),
         .filt_len (filt_len),
         .clr      (clr[i]),
         .cnt_clr  (cnt_clr[i]),
         .tick     (tick[i]),
         .sticky   (sticky[i]),
         .evt_cnt  (evt_cnt[CNT_W*i +: CNT_W])
      );
   end

endmodule

// File: tb/tb_edge_det_multi.sv
// Bench for edge_det_multi: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a run-length
// reference model of the filter, sticky flag and event counter.
module tb_edge_det_multi;

   localparam int NCH    = 4;
   localparam int FILT_W = 4;
   localparam int CNT_W  = 8;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       level;
   logic [2*NCH-1:0]     mode;
   logic [FILT_W-1:0]    filt_len;
   logic [NCH-1:0]       clr;
   logic [NCH-1:0]       cnt_clr;
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       sticky;
   logic [NCH*CNT_W-1:0] evt_cnt;

   edge_det_multi #(
      .NCH    (NCH),
      .FILT_W (FILT_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .level    (level),
      .mode     (mode),
      .filt_len (filt_len),
      .clr      (clr),
      .cnt_clr  (cnt_clr),
      .tick     (tick),
      .sticky   (sticky),
      .evt_cnt  (evt_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // Inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: accepted level and length of the current run of the
   // opposite level; an edge is accepted once the run reaches filt_len+1.
   bit model_on = 1'b0;
   bit acc_m[NCH];
   int run_m[NCH];
   bit stk_m[NCH];
   int cnt_m[NCH];

   initial begin
      for (int i = 0; i < NCH; i++) begin
         acc_m[i] = 1'b0;
         run_m[i] = 0;
         stk_m[i] = 1'b0;
         cnt_m[i] = 0;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         logic [NCH-1:0]       et;
         logic [NCH-1:0]       es;
         logic [NCH*CNT_W-1:0] ec;
         bit                   acc_now[NCH];
         int                   run_nxt[NCH];
         logic [1:0]           md;
         for (int i = 0; i < NCH; i++) begin
            et[i]      = 1'b0;
            es[i]      = stk_m[i];
            ec[CNT_W*i +: CNT_W] = CNT_W'(cnt_m[i]);
            acc_now[i] = 1'b0;
            run_nxt[i] = 0;
            if (!rst) begin
               if (level[i] != acc_m[i]) begin
                  run_nxt[i] = run_m[i] + 1;
                  if (run_nxt[i] >= int'(filt_len) + 1) acc_now[i] = 1'b1;
               end
               if (acc_now[i]) begin
                  md = mode[2*i +: 2];
                  if (level[i]) et[i] = (md == 2'b01) || (md == 2'b11);
                  else          et[i] = (md == 2'b10) || (md == 2'b11);
               end
            end
         end
         check("model_tick",    64'(tick),    64'(et));
         check("model_sticky",  64'(sticky),  64'(es));
         check("model_evt_cnt", 64'(evt_cnt), 64'(ec));
         for (int i = 0; i < NCH; i++) begin
            if (rst) begin
               acc_m[i] = 1'b0;
               run_m[i] = 0;
               stk_m[i] = 1'b0;
               cnt_m[i] = 0;
            end else begin
               if (acc_now[i]) begin
                  acc_m[i] = level[i];
                  run_m[i] = 0;
               end else begin
                  run_m[i] = run_nxt[i];
               end
               if (et[i])       stk_m[i] = 1'b1;
               else if (clr[i]) stk_m[i] = 1'b0;
               if (cnt_clr[i])  cnt_m[i] = et[i] ? 1 : 0;
               else if (et[i])  cnt_m[i] = (cnt_m[i] + 1 > CMAX) ? CMAX : cnt_m[i] + 1;
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      level    = 4'hF;
      mode     = 8'hFF;
      filt_len = 4'd2;
      clr      = '0;
      cnt_clr  = '0;

      // Reset with level high: tick forced low, registers cleared
      step();
      model_on = 1'b1;
      @(negedge clk);
      check("rst_tick",   64'(tick),    64'h0);
      check("rst_sticky", 64'(sticky),  64'h0);
      check("rst_cnt",    64'(evt_cnt), 64'h0);

      // Release with level held high, filt_len=2: tick in 3rd cycle
      step(); rst = 1'b0;
      @(negedge clk); check("rel_c1_tick", 64'(tick), 64'h0);
      step();
      @(negedge clk); check("rel_c2_tick", 64'(tick), 64'h0);
      step();
      @(negedge clk); check("rel_c3_tick", 64'(tick), 64'hF);
      step();
      @(negedge clk);
      check("rel_sticky", 64'(sticky),  64'hF);
      check("rel_cnt",    64'(evt_cnt), 64'h01010101);

      // Fall after 3 low cycles, then reset while a rise is pending
      step(); level = 4'h0;
      step();
      step();
      @(negedge clk); check("fall_f3_tick", 64'(tick), 64'hF);
      step(); level = 4'hF;
      @(negedge clk); check("pend_tick", 64'(tick), 64'h0);
      step(); rst = 1'b1;
      @(negedge clk); check("rst_pend_tick", 64'(tick), 64'h0);
      step(); rst = 1'b0; level = 4'h0;
      @(negedge clk);
      check("rst_pend_tick2",  64'(tick),    64'h0);
      check("rst_pend_sticky", 64'(sticky),  64'h0);
      check("rst_pend_cnt",    64'(evt_cnt), 64'h0);

      // Unfiltered rise-only detection
      step(); filt_len = 4'd0; mode = 8'h55; clr = 4'hF; cnt_clr = 4'hF;
      step(); clr = '0; cnt_clr = '0;
      step(); level = 4'hF;
      @(negedge clk); check("r032_rise_tick", 64'(tick), 64'hF);
      step();
      @(negedge clk);
      check("r032_tick_once", 64'(tick),    64'h0);
      check("r032_sticky",    64'(sticky),  64'hF);
      check("r032_cnt",       64'(evt_cnt), 64'h01010101);
      step(); level = 4'h0;
      @(negedge clk); check("r032_fall_tick", 64'(tick), 64'h0);

      // filt_len=3: a 3-cycle pulse is a glitch, a 4-cycle one is an edge
      step(); filt_len = 4'd3; mode = 8'hFF; cnt_clr = 4'hF;
      step(); cnt_clr = '0; level = 4'hF;
      for (int k = 1; k <= 3; k++) begin
         if (k > 1) step();
         @(negedge clk); check($sformatf("r033_glitch%0d", k), 64'(tick), 64'h0);
      end
      step(); level = 4'h0;
      @(negedge clk); check("r033_glitch_end", 64'(tick), 64'h0);
      step(); level = 4'hF;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) step();
         @(negedge clk); check($sformatf("r033_hi%0d", k), 64'(tick), (k == 4) ? 64'hF : 64'h0);
      end
      step(); level = 4'h0;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) step();
         @(negedge clk); check($sformatf("r033_lo%0d", k), 64'(tick), (k == 4) ? 64'hF : 64'h0);
      end
      step();
      @(negedge clk); check("r033_cnt", 64'(evt_cnt), 64'h02020202);

      // Counter saturation, then clear coincident with a tick
      step(); filt_len = 4'd0; mode = 8'h55; cnt_clr = 4'hF;
      step(); cnt_clr = '0;
      for (int k = 0; k < 300; k++) begin
         level = 4'hF;
         step();
         level = 4'h0;
         step();
      end
      @(negedge clk); check("r034_sat", 64'(evt_cnt), 64'hFFFFFFFF);
      step(); level = 4'hF; cnt_clr = 4'hF;
      @(negedge clk); check("r034_clr_tick", 64'(tick), 64'hF);
      step(); cnt_clr = '0;
      @(negedge clk); check("r034_clr_cnt", 64'(evt_cnt), 64'h01010101);

      // Sticky: tick beats clr, then clr alone clears
      step(); level = 4'h0;
      step(); level = 4'hF; clr = 4'hF;
      @(negedge clk); check("r035_tick", 64'(tick), 64'hF);
      step();
      @(negedge clk); check("r035_sticky_hold", 64'(sticky), 64'hF);
      step(); clr = '0;
      @(negedge clk); check("r035_sticky_clr", 64'(sticky), 64'h0);

      // ch0 off while toggling, then enabled while high: no spurious tick
      step(); mode = 8'hFC; level = 4'h0;
      for (int k = 0; k < 40; k++) begin
         step();
         level[0]   = ~level[0];
         level[3:1] = 3'($urandom);
         @(negedge clk); check("r037_off_tick0", 64'(tick[0]), 64'h0);
      end
      step(); level[0] = 1'b1;
      step(); mode[1:0] = 2'b01;
      @(negedge clk); check("r037_switch_tick0", 64'(tick[0]), 64'h0);

      // Randomized traffic, checked by the model only
      for (int c = 0; c < 4000; c++) begin
         step();
         rst = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 3) == 0) level[i] = ~level[i];
            clr[i]     = ($urandom_range(0, 19) == 0);
            cnt_clr[i] = ($urandom_range(0, 39) == 0);
         end
         if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
         if ($urandom_range(0, 99) == 0)
            filt_len = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      end

      step();
      @(negedge clk);
      model_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
